// File: rtl/writeback_stage_pkg.sv
// Shared opcode map, FSM states and commit-decode helpers for the writeback stage.
// Opcode values match the execute stage's ISA encoding.
package writeback_stage_pkg;

  localparam logic [4:0] OP_MOV   = 5'b00000;
  localparam logic [4:0] OP_ADD   = 5'b00001;
  localparam logic [4:0] OP_SUB   = 5'b00010;
  localparam logic [4:0] OP_MUL   = 5'b00011;
  localparam logic [4:0] OP_DIV   = 5'b00100;
  localparam logic [4:0] OP_ADC   = 5'b00101;
  localparam logic [4:0] OP_SBB   = 5'b00110;
  localparam logic [4:0] OP_AND   = 5'b00111;
  localparam logic [4:0] OP_OR    = 5'b01000;
  localparam logic [4:0] OP_XOR   = 5'b01001;
  localparam logic [4:0] OP_NOT   = 5'b01010;
  localparam logic [4:0] OP_LOAD  = 5'b01011;
  localparam logic [4:0] OP_STORE = 5'b01100;
  localparam logic [4:0] OP_JMP   = 5'b01101;
  localparam logic [4:0] OP_BEQ   = 5'b01110;
  localparam logic [4:0] OP_INC   = 5'b10000;
  localparam logic [4:0] OP_DEC   = 5'b10001;
  localparam logic [4:0] OP_SHL   = 5'b10010;
  localparam logic [4:0] OP_SHR   = 5'b10011;
  localparam logic [4:0] OP_ROL   = 5'b10100;
  localparam logic [4:0] OP_ROR   = 5'b10101;
  localparam logic [4:0] OP_BNE   = 5'b10110;
  localparam logic [4:0] OP_BC    = 5'b10111;
  localparam logic [4:0] OP_BNC   = 5'b11000;
  localparam logic [4:0] OP_CMP   = 5'b11001;
  localparam logic [4:0] OP_HALT  = 5'b11111;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_HIGH = 2'd1,
    S_HALT = 2'd2
  } wb_state_t;

  function automatic logic writes_rd(input logic [4:0] op);
    return (op <= OP_LOAD) || (op >= OP_INC && op <= OP_ROR);
  endfunction

  // Per-bit flag update enables, ordered {Z, C, AC, P}.
  function automatic logic [3:0] flag_mask(input logic [4:0] op);
    logic zp, c, ac;
    ac = (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADC) || (op == OP_SBB);
    c  = ac || (op >= OP_INC && op <= OP_SHR);
    zp = (op <= OP_NOT) || (op >= OP_INC && op <= OP_ROR) || (op == OP_CMP);
    return {zp, c, ac, zp};
  endfunction

endpackage

// File: rtl/writeback_stage_flag_reg.sv
// Committed flag register {Z, C, AC, P}; each bit loads only when its enable is set.
module wb_flag_reg (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] en,
  input  logic [3:0] d,
  output logic [3:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (en[i]) q[i] <= d[i];
      end
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: commits execute results to the register file, data memory and
// flags; splits 16-bit MUL/DIV results into two byte writes and latches HALT.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned REG_AW     = 3,
  parameter int unsigned MEM_AW     = 4,
  parameter int unsigned SPLIT_WIDE = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4:0]          opcode,
  input  logic [REG_AW-1:0]   rd,
  input  logic [MEM_AW-1:0]   mem_addr,
  input  logic [2*DATA_W-1:0] result,
  input  logic                zero_flag,
  input  logic                carry_flag,
  input  logic                ac_flag,
  input  logic                parity_flag,
  output logic                rf_we,
  output logic [REG_AW-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic                dm_we,
  output logic [MEM_AW-1:0]   dm_addr,
  output logic [DATA_W-1:0]   dm_wdata,
  output logic [3:0]          flags_q,
  output logic                retired,
  output logic                halted
);

  wb_state_t state, state_nx;

  logic              transfer, is_wide, hi_load;
  logic              rf_we_nx, dm_we_nx, retired_nx, halted_nx;
  logic [REG_AW-1:0] waddr_nx, hi_addr;
  logic [DATA_W-1:0] wdata_nx, dm_wdata_nx, hi_data;
  logic [MEM_AW-1:0] dm_addr_nx;
  logic [3:0]        flag_en;

  // Gated by reset so the handshake reads 0 while reset is held.
  assign in_ready = (state == S_RUN) && !reset;
  assign transfer = in_valid && in_ready;
  assign is_wide  = (SPLIT_WIDE != 0) && (opcode == OP_MUL || opcode == OP_DIV);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_RUN;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    hi_load     = 1'b0;
    rf_we_nx    = 1'b0;
    dm_we_nx    = 1'b0;
    retired_nx  = 1'b0;
    halted_nx   = halted;
    waddr_nx    = rf_waddr;
    wdata_nx    = rf_wdata;
    dm_addr_nx  = dm_addr;
    dm_wdata_nx = dm_wdata;
    flag_en     = 4'b0000;
    unique case (state)
      S_RUN: begin
        if (transfer) begin
          flag_en = flag_mask(opcode);
          if (writes_rd(opcode)) begin
            rf_we_nx = 1'b1;
            waddr_nx = rd;
            wdata_nx = result[DATA_W-1:0];
          end
          if (opcode == OP_STORE) begin
            dm_we_nx    = 1'b1;
            dm_addr_nx  = mem_addr;
            dm_wdata_nx = result[DATA_W-1:0];
          end
          if (is_wide) begin
            hi_load  = 1'b1;
            state_nx = S_HIGH;
          end else begin
            retired_nx = 1'b1;
          end
          if (opcode == OP_HALT) begin
            halted_nx = 1'b1;
            state_nx  = S_HALT;
          end
        end
      end
      S_HIGH: begin
        rf_we_nx   = 1'b1;
        waddr_nx   = hi_addr;
        wdata_nx   = hi_data;
        retired_nx = 1'b1;
        state_nx   = S_RUN;
      end
      S_HALT: begin
        state_nx = S_HALT;
      end
      default: begin
        state_nx = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      dm_we    <= 1'b0;
      dm_addr  <= '0;
      dm_wdata <= '0;
      retired  <= 1'b0;
      halted   <= 1'b0;
      hi_addr  <= '0;
      hi_data  <= '0;
    end else begin
      rf_we    <= rf_we_nx;
      rf_waddr <= waddr_nx;
      rf_wdata <= wdata_nx;
      dm_we    <= dm_we_nx;
      dm_addr  <= dm_addr_nx;
      dm_wdata <= dm_wdata_nx;
      retired  <= retired_nx;
      halted   <= halted_nx;
      // High byte goes to the next register up, wrapping r7 -> r0.
      if (hi_load) begin
        hi_addr <= rd + REG_AW'(1);
        hi_data <= result[2*DATA_W-1:DATA_W];
      end
    end
  end

  wb_flag_reg u_flag_reg (
    .clk   (clk),
    .reset (reset),
    .en    (flag_en),
    .d     ({zero_flag, carry_flag, ac_flag, parity_flag}),
    .q     (flags_q)
  );

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized scoreboard bench for writeback_stage: a table-driven model queues the expected
// commit events, and a monitor compares them whenever the stage strobes.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  opcode;
  logic [2:0]  rd;
  logic [3:0]  mem_addr;
  logic [15:0] result;
  logic        zero_flag, carry_flag, ac_flag, parity_flag;
  logic        rf_we, dm_we, retired, halted;
  logic [2:0]  rf_waddr;
  logic [7:0]  rf_wdata, dm_wdata;
  logic [3:0]  dm_addr, flags_q;

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .opcode      (opcode),
    .rd          (rd),
    .mem_addr    (mem_addr),
    .result      (result),
    .zero_flag   (zero_flag),
    .carry_flag  (carry_flag),
    .ac_flag     (ac_flag),
    .parity_flag (parity_flag),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .dm_we       (dm_we),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .flags_q     (flags_q),
    .retired     (retired),
    .halted      (halted)
  );

  typedef struct packed {
    logic       rf_we;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic       dm_we;
    logic [3:0] daddr;
    logic [7:0] ddata;
    logic       retired;
    logic [3:0] flags;
    logic       halted;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state
  bit       wr_rd[32], upd_zp[32], upd_c[32], upd_ac[32];
  logic [3:0] m_flags;
  bit       m_halted, hi_pending, exp_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rf_we"},    32'(rf_we),    0);
    chk({tag, "_rf_waddr"}, 32'(rf_waddr), 0);
    chk({tag, "_rf_wdata"}, 32'(rf_wdata), 0);
    chk({tag, "_dm_we"},    32'(dm_we),    0);
    chk({tag, "_dm_addr"},  32'(dm_addr),  0);
    chk({tag, "_dm_wdata"}, 32'(dm_wdata), 0);
    chk({tag, "_flags"},    32'(flags_q),  0);
    chk({tag, "_retired"},  32'(retired),  0);
    chk({tag, "_halted"},   32'(halted),   0);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_flags    = 4'b0000;
    m_halted   = 1'b0;
    hi_pending = 1'b0;
    exp_ready  = 1'b1;
  endtask

  task automatic commit(input logic [4:0] op, input logic [2:0] r, input logic [3:0] ma,
                        input logic [15:0] res, input logic [3:0] fl);
    exp_t e;
    int   hi;
    e = '0;
    if (wr_rd[op]) begin
      e.rf_we = 1'b1;
      e.waddr = r;
      e.wdata = res[7:0];
    end
    if (op == 5'd12) begin
      e.dm_we = 1'b1;
      e.daddr = ma;
      e.ddata = res[7:0];
    end
    if (upd_zp[op]) begin
      m_flags[3] = fl[3];
      m_flags[0] = fl[0];
    end
    if (upd_c[op])  m_flags[2] = fl[2];
    if (upd_ac[op]) m_flags[1] = fl[1];
    if (op == 5'd31) begin
      m_halted  = 1'b1;
      exp_ready = 1'b0;
    end
    e.flags  = m_flags;
    e.halted = m_halted;
    if (op == 5'd3 || op == 5'd4) begin
      exp_q.push_back(e);
      hi        = (int'(r) + 1) % 8;
      e.rf_we   = 1'b1;
      e.waddr   = 3'(hi);
      e.wdata   = res[15:8];
      e.retired = 1'b1;
      exp_q.push_back(e);
      hi_pending = 1'b1;
      exp_ready  = 1'b0;
    end else begin
      e.retired = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [2:0] r,
                       input logic [3:0] ma, input logic [15:0] res, input logic [3:0] fl);
    @(negedge clk);
    in_valid = v;
    opcode   = op;
    rd       = r;
    mem_addr = ma;
    result   = res;
    {zero_flag, carry_flag, ac_flag, parity_flag} = fl;
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    @(posedge clk);
    if (hi_pending) begin
      hi_pending = 1'b0;
      exp_ready  = !m_halted;
    end else if (v && exp_ready) begin
      commit(op, r, ma, res, fl);
    end
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 3'd0, 4'd0, 16'h0000, 4'b0000);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && (rf_we || dm_we || retired)) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL spurious_strobe: rf_we=%0b dm_we=%0b retired=%0b, expected no strobe (t=%0t)",
                   rf_we, dm_we, retired, $time);
        end else begin
          e = exp_q.pop_front();
          chk("rf_we",   32'(rf_we),   32'(e.rf_we));
          chk("dm_we",   32'(dm_we),   32'(e.dm_we));
          chk("retired", 32'(retired), 32'(e.retired));
          if (e.rf_we) begin
            chk("rf_waddr", 32'(rf_waddr), 32'(e.waddr));
            chk("rf_wdata", 32'(rf_wdata), 32'(e.wdata));
          end
          if (e.dm_we) begin
            chk("dm_addr",  32'(dm_addr),  32'(e.daddr));
            chk("dm_wdata", 32'(dm_wdata), 32'(e.ddata));
          end
          chk("flags_q", 32'(flags_q), 32'(e.flags));
          chk("halted",  32'(halted),  32'(e.halted));
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [4:0] op;
    for (int i = 0; i < 32; i++) begin
      wr_rd[i]  = (i <= 11) || (i >= 16 && i <= 21);
      upd_zp[i] = (i <= 10) || (i >= 16 && i <= 21) || (i == 25);
      upd_ac[i] = (i == 1) || (i == 2) || (i == 5) || (i == 6);
      upd_c[i]  = upd_ac[i] || (i >= 16 && i <= 19);
    end
    model_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    opcode   = '0;
    rd       = '0;
    mem_addr = '0;
    result   = '0;
    {zero_flag, carry_flag, ac_flag, parity_flag} = 4'b0000;
    #2;
    chk_zero("por");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // ADD r2 = A5 with carry
    drive(1'b1, 5'd1, 3'd2, 4'd0, 16'h00A5, 4'b0100);
    // MUL r7 = 1234, immediately followed by an ADD that must stall one cycle
    drive(1'b1, 5'd3, 3'd7, 4'd0, 16'h1234, 4'b0000);
    drive(1'b1, 5'd1, 3'd1, 4'd0, 16'h0011, 4'b0010);
    drive(1'b1, 5'd1, 3'd1, 4'd0, 16'h0011, 4'b0010);
    // STORE 3C to address F
    drive(1'b1, 5'd12, 3'd4, 4'hF, 16'h003C, 4'b1111);
    // SUB giving zero, then BEQ
    drive(1'b1, 5'd2, 3'd3, 4'd0, 16'h0000, 4'b1001);
    drive(1'b1, 5'd14, 3'd5, 4'd0, 16'h0077, 4'b0110);
    idle();

    for (int i = 0; i < 400; i++) begin
      op = 5'($urandom_range(0, 30));
      drive(1'($urandom_range(0, 9) < 7), op, 3'($urandom), 4'($urandom),
            16'($urandom), 4'($urandom));
    end
    repeat (3) idle();

    // Reset while the DIV high byte is pending
    drive(1'b1, 5'd4, 3'd5, 4'd0, 16'hBEEF, 4'b1010);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_zero("mid_high_reset");
    model_reset();
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) idle();
    drive(1'b1, 5'd0, 3'd6, 4'd0, 16'h005A, 4'b0001);
    idle();

    // HALT, then keep offering instructions
    drive(1'b1, 5'd31, 3'd0, 4'd0, 16'h0000, 4'b1111);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'd1, 3'(i), 4'd0, 16'h00FF, 4'b1111);
      chk("halted_sticky", 32'(halted), 1);
    end
    repeat (3) idle();
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
